// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared types and constants for the UART boot loader.
//   boot_state_e      - loader FSM states
//   err_code_t        - error code encoding reported on err_code
//   DEFAULT_SYNC_BYTE - default frame start marker
package uart_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCntLo,
    StCntHi,
    StData,
    StCsum,
    StDone,
    StError
  } boot_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_CSUM    = 2'b01;
  localparam err_code_t ERR_OVF     = 2'b10;
  localparam err_code_t ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

  // True while a frame is being received (header, payload or checksum).
  function automatic logic in_frame(boot_state_e s);
    return (s == StCntLo) || (s == StCntHi) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/boot_timeout_timer.sv
// boot_timeout_timer: inter-byte idle timer for the boot loader.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clr     - a byte arrived this cycle; restart the idle count
//   en      - timer is armed (a frame is in progress)
//   expired - one-cycle pulse: TIMEOUT_CYCLES cycles have elapsed since the last clr
module boot_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  // count_q holds the number of cycles elapsed since the last strobe cycle, so the
  // strobe cycle itself counts as zero and the next cycle sees one.
  logic [CntW-1:0] count_q;

  // A strobe in the same cycle always wins over expiry.
  assign expired = en && !clr && (count_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= CntW'(1);
    end else if (!en) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: decodes a framed program image from the UART byte stream and
// writes it word by word into instruction memory, holding the CPU in reset until
// a complete frame with a matching checksum has been loaded.
// Frame: SYNC_BYTE, count_lo, count_hi, 4*count payload bytes (LSB first), checksum.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   rx_valid  - one-cycle strobe, rx_data holds a new byte
//   rx_data   - received byte
//   load_req  - one-cycle pulse, re-arm from DONE or ERROR
//   mem_we    - one-cycle instruction-memory write strobe
//   mem_addr  - word address of the write
//   mem_wdata - write data
//   cpu_rst   - CPU reset hold, active-high
//   busy      - frame in progress
//   done      - image loaded and verified
//   error     - sticky failure flag
//   err_code  - 00 none, 01 checksum, 10 overflow, 11 timeout
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  load_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam logic [32:0] MaxWords = 33'd1 << ADDR_WIDTH;

  boot_state_e           state_q;
  logic [7:0]            count_lo_q;
  logic [15:0]           words_left_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [1:0]            lane_q;
  logic [23:0]           word_q;   // lanes 0..2 of the word being assembled
  logic [7:0]            sum_q;

  logic [15:0] count_full;
  logic        overflow;
  logic        timer_en;
  logic        timeout;

  assign count_full = {rx_data, count_lo_q};
  assign overflow   = {17'd0, count_full} > MaxWords;
  assign timer_en   = in_frame(state_q);

  boot_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid),
    .en     (timer_en),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_lo_q   <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q    <= StCntLo;
            busy       <= 1'b1;
            word_idx_q <= '0;
            lane_q     <= '0;
            sum_q      <= '0;
          end
        end
        StCntLo: begin
          if (rx_valid) begin
            count_lo_q <= rx_data;
            state_q    <= StCntHi;
          end
        end
        StCntHi: begin
          if (rx_valid) begin
            if (overflow) begin
              state_q  <= StError;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_OVF;
            end else if (count_full == 16'd0) begin
              state_q <= StCsum;
            end else begin
              words_left_q <= count_full;
              state_q      <= StData;
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            sum_q  <= sum_q + rx_data;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= word_idx_q;
              mem_wdata    <= {rx_data, word_q};
              word_idx_q   <= word_idx_q + ADDR_WIDTH'(1);
              words_left_q <= words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
                state_q <= StCsum;
              end
            end else begin
              // Shift down so byte 0 ends up in bits [7:0] after three lanes.
              word_q <= {rx_data, word_q[23:8]};
            end
          end
        end
        StCsum: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == sum_q) begin
              state_q <= StDone;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state_q  <= StError;
              error    <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
        StDone: begin
          // Any byte arriving with load_req is dropped.
          if (load_req) begin
            state_q <= StIdle;
            done    <= 1'b0;
            cpu_rst <= 1'b1;
          end
        end
        StError: begin
          if (load_req) begin
            state_q  <= StIdle;
            error    <= 1'b0;
            err_code <= ERR_NONE;
          end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q    <= StCntLo;
            busy       <= 1'b1;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            word_idx_q <= '0;
            lane_q     <= '0;
            sum_q      <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Only fires inside a frame on a cycle without a byte, so it never races
      // a case branch above.
      if (timeout) begin
        state_q  <= StError;
        busy     <= 1'b0;
        error    <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          load_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  uart_boot_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'h55),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .load_req (load_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed memory writes, sampled mid-cycle.
  int unsigned obs_addr[$];
  logic [31:0] obs_data[$];
  int unsigned obs_cyc[$];
  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(mem_wdata);
      obs_cyc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame under test and the cycle at which each of its bytes was strobed.
  logic [7:0]  frm[$];
  int unsigned frm_cyc[$];

  // Reference expectations.
  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_last[$];
  logic        exp_done;
  logic [1:0]  exp_code;

  // Byte-level frame interpretation: what a correct loader must do with frm.
  task automatic model_frame();
    int         n;
    int         b;
    logic [7:0] s;
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    exp_done = 1'b0;
    n = int'(frm[1]) + 256 * int'(frm[2]);
    if (n > (1 << AW)) begin
      exp_code = 2'b10;
      return;
    end
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      b = 3 + 4 * i;
      if (b + 3 >= frm.size()) begin
        exp_code = 2'b11;
        return;
      end
      exp_addr.push_back(i);
      exp_data.push_back({frm[b+3], frm[b+2], frm[b+1], frm[b]});
      exp_last.push_back(b + 3);
      s = s + frm[b] + frm[b+1] + frm[b+2] + frm[b+3];
    end
    if (3 + 4 * n >= frm.size()) begin
      exp_code = 2'b11;
    end else if (frm[3+4*n] == s) begin
      exp_done = 1'b1;
      exp_code = 2'b00;
    end else begin
      exp_code = 2'b01;
    end
  endtask

  task automatic append_csum(input logic [7:0] delta);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 3; i < frm.size(); i++) s = s + frm[i];
    frm.push_back(s + delta);
  endtask

  // Called at a negedge; returns at a negedge, gap cycles after the strobe.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_frame_gap(input int slow_idx, input int slow_gap, input int gap);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    frm_cyc.delete();
    foreach (frm[i]) begin
      frm_cyc.push_back(cyc);
      send_byte(frm[i], (i == slow_idx) ? slow_gap : gap);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic [1:0] code,
                              input logic b);
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
    check_eq({tag, "_error"}, 32'(error), 32'(code != 2'b00));
    check_eq({tag, "_err_code"}, 32'(err_code), 32'(code));
    check_eq({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic check_frame(input string tag);
    model_frame();
    check_eq({tag, "_nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check_eq($sformatf("%s_w%0d_addr", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
      check_eq($sformatf("%s_w%0d_data", tag, i), obs_data[i], exp_data[i]);
      check_eq($sformatf("%s_w%0d_lat", tag, i), 32'(obs_cyc[i]),
               32'(frm_cyc[exp_last[i]] + 1));
    end
    check_status(tag, exp_done, exp_code, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_status(tag, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    int          n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-word frame with a good checksum.
    frm = '{8'h55, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    run_frame_gap(-1, 0, 4);
    check_frame("good2");
    check_eq("good2_w0_const", (obs_data.size() > 0) ? obs_data[0] : 32'd0, 32'h12345678);
    check_eq("good2_w1_const", (obs_data.size() > 1) ? obs_data[1] : 32'd0, 32'hDEADBEEF);
    pulse_load();
    check_status("reload", 1'b0, 2'b00, 1'b0);

    // Bad checksum, then recovery by a fresh frame straight from ERROR.
    frm[11] = 8'h4D;
    run_frame_gap(-1, 0, 4);
    check_frame("badcsum");
    frm[11] = 8'h4C;
    run_frame_gap(-1, 0, 4);
    check_frame("recover");
    pulse_load();

    // Word count one beyond capacity; error must appear the cycle after count_hi.
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    send_byte(8'h55, 4);
    send_byte(8'h01, 4);
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq("ovf_error", 32'(error), 32'd1);
    check_eq("ovf_err_code", 32'(err_code), 32'd2);
    repeat (3) @(negedge clk);
    frm = '{8'h55, 8'h01, 8'h04};
    frm_cyc.delete();
    check_frame("ovf");
    pulse_load();
    check_status("ovf_clear", 1'b0, 2'b00, 1'b0);

    // Empty image, then load_req colliding with a SYNC byte in DONE.
    frm = '{8'h55, 8'h00, 8'h00, 8'h00};
    run_frame_gap(-1, 0, 4);
    check_frame("zero");
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check_status("load_vs_byte", 1'b0, 2'b00, 1'b0);

    // A byte landing on the would-be expiry cycle keeps the frame alive.
    frm = '{8'h55, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    append_csum(8'h00);
    run_frame_gap(3, int'(TO) - 1, 4);
    check_frame("byte_wins");
    pulse_load();

    // Stall after two payload bytes.
    frm = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22};
    run_frame_gap(-1, 0, 4);
    t = frm_cyc[4];
    while (cyc < t + TO - 1) @(negedge clk);
    check_eq("to_early_error", 32'(error), 32'd0);
    check_eq("to_early_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_frame("timeout");
    pulse_load();

    // Reset mid-frame after six payload bytes.
    frm = '{8'h55, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    append_csum(8'h00);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    for (int i = 0; i < 9; i++) send_byte(frm[i], 4);
    check_eq("pre_rst_nwr", 32'(obs_addr.size()), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_nwr", 32'(obs_addr.size()), 32'd1);
    run_frame_gap(-1, 0, 4);
    check_frame("after_rst");
    pulse_load();

    // Full-capacity image: last write lands at the top address.
    frm = '{8'h55, 8'h00, 8'h04};
    for (int i = 0; i < 4 * (1 << AW); i++) frm.push_back(8'($urandom));
    append_csum(8'h00);
    run_frame_gap(-1, 0, 4);
    check_frame("full");
    pulse_load();

    // Randomized frames with noise, random gaps and occasional bad checksums.
    for (int r = 0; r < 10; r++) begin
      logic [7:0] nb;
      n = int'($urandom_range(0, 6));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        nb = 8'($urandom);
        if (nb == 8'h55) nb = 8'hAA;
        send_byte(nb, 4);
      end
      frm = '{8'h55};
      frm.push_back(8'(n));
      frm.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
      append_csum(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      run_frame_gap(-1, 0, int'($urandom_range(4, 7)));
      check_frame($sformatf("rnd%0d", r));
      if (exp_done) begin
        pulse_load();
        check_status($sformatf("rnd%0d_load", r), 1'b0, 2'b00, 1'b0);
      end else if ($urandom_range(0, 1) == 1) begin
        pulse_load();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Controls the UART byte receiver during boot.
- Consumes its byte stream, decodes a framed program image and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction memory.
- Holds the CPU in reset until a frame is loaded and its checksum passes.
- Sits between the receiver's byte output and the instruction-memory write port.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CYCLES, 10_000_000, maximum idle clk cycles between bytes inside a frame (100 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  input  8  received byte
- load_req  input  1  one-cycle pulse: re-arm the loader from DONE
- mem_we  output  1  one-cycle instruction-memory write strobe
- mem_addr  output  ADDR_WIDTH  word address of the write
- mem_wdata  output  32  write data
- cpu_rst  output  1  CPU reset hold, active-high
- busy  output  1  a frame is in progress (CNT_LO..CSUM)
- done  output  1  image loaded and verified
- error  output  1  sticky failure flag
- err_code  output  2  00 none, 01 checksum, 10 overflow, 11 timeout

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, err_code=00. State goes to IDLE.
- Frame format: SYNC_BYTE; count_lo; count_hi (16-bit word count N); 4*N payload bytes, LSB first per word; one checksum byte.
- Checksum: 8-bit sum mod 256 of the payload bytes only.
- IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> CNT_LO; clear word index, byte lane and running sum.
- CNT_LO: the next byte is stored as count[7:0] -> CNT_HI.
- CNT_HI: the next byte is stored as count[15:8].
  - count > 2^ADDR_WIDTH -> ERROR, err_code=10, evaluated the cycle after the byte.
  - count == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: each byte fills lane 0..3 of the word register and is added to the sum.
  - On lane 3, the cycle after the byte: mem_we=1 for exactly one cycle, mem_addr=word index, mem_wdata=the assembled word.
  - The word index then increments.
  - After word N-1 -> CSUM.
  - Latency: 4th byte strobe at cycle t -> mem_we at t+1.
- CSUM: byte == sum -> DONE. Otherwise -> ERROR with err_code=01.
- DONE: done=1, cpu_rst=0. rx bytes are ignored. load_req -> IDLE with cpu_rst=1 and done=0.
- ERROR: error=1, cpu_rst=1; err_code is held.
  - A SYNC_BYTE restarts the frame (-> CNT_LO) and clears error and err_code.
  - load_req also -> IDLE, clearing error.
- Timeout: the counter resets on every rx_valid and runs only in CNT_LO..CSUM. At TIMEOUT_CYCLES -> ERROR with err_code=11. The timeout is not active in IDLE, DONE or ERROR.
- Simultaneous events:
  - load_req and rx_valid in the same cycle in DONE: load_req wins and the byte is dropped.
  - rx_valid and timeout expiry in the same cycle: the byte wins and the counter resets.
- rst asserted mid-frame: abort immediately, apply the reset values; no partial-word write.
- Bytes arrive at most once per 4 cycles; the block needs no backpressure.
- Word address does not wrap: the overflow check guarantees index < 2^ADDR_WIDTH.

Decomposition:
- Package uart_boot_pkg holds:
  - state encoding: IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR;
  - err_code constants: ERR_NONE, ERR_CSUM, ERR_OVF, ERR_TIMEOUT;
  - default SYNC_BYTE.
- One sub-module, boot_timeout_timer: a clear/enable counter with an expiry pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Frame 55 02 00 | 78 56 34 12 | EF BE AD DE | checksum = payload sum mod 256 -> mem_we at addr 0 with 12345678 and addr 1 with DEADBEEF, one cycle after each 4th byte; then done=1, cpu_rst=0.
- Same frame with the checksum byte +1 -> no done; error=1, err_code=01, cpu_rst stays 1. A following valid frame recovers to done=1 and err_code=00.
- Frame 55 01 04 with ADDR_WIDTH=10 (count 1025) -> ERROR, err_code=10, no mem_we.
- Frame 55 00 00 followed by checksum 00 -> done=1 with zero writes. A following load_req -> cpu_rst=1, done=0, IDLE.
- Frame stalls after 2 payload bytes for TIMEOUT_CYCLES (set to 100 in the bench) -> error with err_code=11 at cycle 100 after the last strobe; no partial write.
- rst pulsed after 6 payload bytes, then a full valid frame -> all outputs at reset values; the new frame writes from addr 0 and the old partial word is never written.
